// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: class codes, data-proc command codes,
// field bit positions and the combinational encode function used by instr_encoder.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    CLS_DP  = 2'd0,
    CLS_MEM = 2'd1,
    CLS_BR  = 2'd2,
    CLS_ILL = 2'd3
  } cls_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  localparam int COND_LSB  = 28;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_LSB = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int SRC2_LSB  = 0;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic              legal;
    logic [WORD_W-1:0] word;
  } enc_t;

  function automatic enc_t encode(
    input logic [1:0]  cls,
    input logic [3:0]  cond,
    input logic [3:0]  cmd,
    input logic        imm,
    input logic        s,
    input logic        load,
    input logic [3:0]  rn,
    input logic [3:0]  rd,
    input logic [11:0] src2,
    input logic [23:0] imm24
  );
    enc_t       r;
    logic       s_eff;
    logic [3:0] rd_eff;
    r      = '0;
    s_eff  = s;
    rd_eff = rd;
    r.word[COND_LSB +: 4] = cond;
    r.word[OP_LSB +: 2]   = cls;
    case (cls)
      CLS_DP: begin
        case (cmd)
          CMD_AND, CMD_SUB, CMD_ADD, CMD_TST,
          CMD_CMP, CMD_CMN, CMD_ORR, CMD_LSL: r.legal = 1'b1;
          default:                            r.legal = 1'b0;
        endcase
        // Compare-type ops only set flags: S forced on, no destination register.
        if (cmd == CMD_CMP || cmd == CMD_TST || cmd == CMD_CMN) begin
          s_eff  = 1'b1;
          rd_eff = 4'b0000;
        end
        r.word[FUNCT_LSB +: 6] = {imm, cmd, s_eff};
        r.word[RN_LSB +: 4]    = rn;
        r.word[RD_LSB +: 4]    = rd_eff;
        r.word[SRC2_LSB +: 12] = src2;
      end
      CLS_MEM: begin
        r.legal                = 1'b1;
        r.word[FUNCT_LSB +: 6] = {~imm, 4'b1100, load};
        r.word[RN_LSB +: 4]    = rn;
        r.word[RD_LSB +: 4]    = rd;
        r.word[SRC2_LSB +: 12] = src2;
      end
      CLS_BR: begin
        r.legal        = 1'b1;
        r.word[25:24]  = 2'b10;
        r.word[23:0]   = imm24;
      end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO; entry 0 is always the head. Occupancy is exported so the
// parent can derive its ready and so checkers can observe the buffer state.
module enc_fifo2 #(
  parameter int W = 40
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         valid_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]   occ_q, occ_d;
  logic         push_ok, pop_ok;

  assign push_ok = push_i && (occ_q != 2'd2);
  assign pop_ok  = pop_i && (occ_q != 2'd0);

  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else if (push_ok && pop_ok) begin
      // Occupancy unchanged; new word lands behind whatever remains.
      if (occ_q == 2'd1) begin
        mem0_d = din_i;
      end else begin
        mem0_d = mem1_q;
        mem1_d = din_i;
      end
    end else if (push_ok) begin
      if (occ_q == 2'd0) mem0_d = din_i;
      else               mem1_d = din_i;
      occ_d = occ_q + 2'd1;
    end else if (pop_ok) begin
      mem0_d = mem1_q;
      occ_d  = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem0_q <= '0;
      mem1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o  = mem0_q;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: combinational field packing, address tagging and
// illegal-input accounting in front of a 2-entry output buffer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_cls,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_cmd,
  input  logic        in_imm,
  input  logic        in_s,
  input  logic        in_load,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [11:0] in_src2,
  input  logic [23:0] in_imm24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [7:0]  out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  enc_t        enc;
  logic        accept, push, bad;
  logic [1:0]  occ;
  logic [39:0] fifo_dout;
  logic [7:0]  addr_q, addr_d, err_cnt_q, err_cnt_d;
  logic        err_q, err_d;

  assign enc = encode(in_cls, in_cond, in_cmd, in_imm, in_s, in_load,
                      in_rn, in_rd, in_src2, in_imm24);

  // start drops the coincident input; illegal words are consumed but never buffered.
  assign accept = in_valid && in_ready && !start;
  assign push   = accept && enc.legal;
  assign bad    = accept && !enc.legal;

  always_comb begin
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (start) begin
      addr_d    = 8'd0;
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end else begin
      if (push) addr_d = addr_q + 8'd1;
      if (bad) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= 8'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  enc_fifo2 #(.W(40)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (start),
    .push_i  (push),
    .din_i   ({addr_q, enc.word}),
    .pop_i   (out_ready),
    .dout_o  (fifo_dout),
    .valid_o (out_valid),
    .occ_o   (occ)
  );

  assign in_ready = (occ != 2'd2);
  assign out_addr = fifo_dout[39:32];
  assign out_word = fifo_dout[31:0];
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [1:0]  in_cls;
  logic [3:0]  in_cond, in_cmd, in_rn, in_rd;
  logic        in_imm, in_s, in_load;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        out_valid, out_ready, err;
  logic [31:0] out_word;
  logic [7:0]  out_addr, err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  m_addr;
  logic        m_err;
  logic [7:0]  m_cnt;

  logic [3:0] legal_cmds [8] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100,
                                 4'b1010, 4'b1000, 4'b1101, 4'b1011};

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_cond(in_cond), .in_cmd(in_cmd), .in_imm(in_imm),
    .in_s(in_s), .in_load(in_load), .in_rn(in_rn), .in_rd(in_rd),
    .in_src2(in_src2), .in_imm24(in_imm24),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding built from field arithmetic on the current inputs.
  function automatic logic [32:0] ref_encode();
    longint w;
    bit     legal, flags_only;
    w = 0;
    legal = 0;
    flags_only = in_cmd inside {4'b1010, 4'b1000, 4'b1011};
    case (in_cls)
      2'd0: begin
        legal = (in_cmd inside {legal_cmds});
        w = (longint'(in_cond) << 28) + (longint'(in_imm) << 25) + (longint'(in_cmd) << 21)
          + (longint'(flags_only ? 1'b1 : in_s) << 20) + (longint'(in_rn) << 16)
          + (longint'(flags_only ? 4'd0 : in_rd) << 12) + longint'(in_src2);
      end
      2'd1: begin
        legal = 1;
        w = (longint'(in_cond) << 28) + (longint'(1) << 26) + (longint'(!in_imm) << 25)
          + (longint'(3) << 23) + (longint'(in_load) << 20) + (longint'(in_rn) << 16)
          + (longint'(in_rd) << 12) + longint'(in_src2);
      end
      2'd2: begin
        legal = 1;
        w = (longint'(in_cond) << 28) + (longint'(2) << 26) + (longint'(2) << 24)
          + longint'(in_imm24);
      end
      default: legal = 0;
    endcase
    return {legal, w[31:0]};
  endfunction

  task automatic model_update();
    logic [32:0] r;
    bit pop, acc;
    r = ref_encode();
    if (start) begin
      exp_q.delete();
      m_addr = 0; m_err = 0; m_cnt = 0;
    end else begin
      pop = (exp_q.size() > 0) && out_ready;
      acc = in_valid && (exp_q.size() < 2);
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        if (r[32]) begin
          exp_q.push_back({m_addr, r[31:0]});
          m_addr++;
        end else begin
          m_err = 1;
          if (m_cnt != 8'hFF) m_cnt++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("in_ready", in_ready, exp_q.size() < 2);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_addr_word", {out_addr, out_word}, exp_q[0]);
    check("err", err, m_err);
    check("err_cnt", err_cnt, m_cnt);
  endtask

  // Inputs are set just after a falling edge; the model mirrors the next rising edge.
  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input logic v, input logic [1:0] cls, input logic [3:0] cond,
                        input logic [3:0] cmd, input logic imm, input logic s, input logic ld,
                        input logic [3:0] rn, input logic [3:0] rd, input logic [11:0] src2,
                        input logic [23:0] imm24);
    in_valid = v; in_cls = cls; in_cond = cond; in_cmd = cmd; in_imm = imm; in_s = s;
    in_load = ld; in_rn = rn; in_rd = rd; in_src2 = src2; in_imm24 = imm24;
  endtask

  task automatic rand_fields(input bit legal_only);
    in_cls   = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 3));
    in_cmd   = ($urandom_range(0, 1) == 0 || legal_only) ? legal_cmds[$urandom_range(0, 7)]
                                                         : 4'($urandom_range(0, 15));
    in_cond  = 4'($urandom_range(0, 15));
    in_imm   = 1'($urandom_range(0, 1));
    in_s     = 1'($urandom_range(0, 1));
    in_load  = 1'($urandom_range(0, 1));
    in_rn    = 4'($urandom_range(0, 15));
    in_rd    = 4'($urandom_range(0, 15));
    in_src2  = 12'($urandom_range(0, 4095));
    in_imm24 = 24'($urandom);
  endtask

  task automatic do_pop();
    in_valid = 0; out_ready = 1; start = 0;
    tick();
    out_ready = 0;
  endtask

  initial begin
    reset = 1; start = 0; out_ready = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_addr = 0; m_err = 0; m_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    reset = 0;
    @(negedge clk);

    // Reference vectors
    set_in(1, 0, 4'hE, 4'b0100, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0);
    tick();
    check("add_word", out_word, 32'hE2821005);
    check("add_addr", out_addr, 8'h00);
    do_pop();
    set_in(1, 1, 4'hE, 4'b0000, 1, 0, 1, 4'd4, 4'd3, 12'h008, 0);
    tick();
    check("ldr_word", out_word, 32'hE5943008);
    check("ldr_addr", out_addr, 8'h01);
    do_pop();
    set_in(1, 0, 4'hE, 4'b1010, 1, 0, 0, 4'd0, 4'd7, 12'h000, 0);
    tick();
    check("cmp_word", out_word, 32'hE3500000);
    do_pop();
    set_in(1, 2, 4'hE, 4'b0000, 0, 0, 0, 4'd5, 4'd6, 12'hABC, 24'h000010);
    tick();
    check("b_word", out_word, 32'hEA000010);
    check("b_addr", out_addr, 8'h03);
    do_pop();
    set_in(1, 3, 4'hE, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ill_out_valid", out_valid, 0);
    check("ill_err", err, 1);
    check("ill_err_cnt", err_cnt, 1);
    set_in(1, 0, 4'hE, 4'b0100, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0);
    tick();
    check("post_ill_addr", out_addr, 8'h04);
    do_pop();

    // Backpressure: third push must be refused, then drain in order
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_fields(1); in_valid = 1;
      tick();
    end
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    in_valid = 0; out_ready = 1;
    tick(); tick(); tick();
    out_ready = 0;

    // Address wrap across 257 words
    start = 1; in_valid = 0;
    tick();
    start = 0; out_ready = 1;
    for (int i = 0; i < 257; i++) begin
      rand_fields(1); in_valid = 1;
      tick();
    end
    check("wrap_addr", out_addr, 8'h00);
    check("wrap_valid", out_valid, 1);

    // start with a push pending drops the push and clears everything
    out_ready = 0; start = 1; rand_fields(1); in_valid = 1;
    tick();
    start = 0;
    check("start_empty", out_valid, 0);
    check("start_ready", in_ready, 1);
    rand_fields(1); in_valid = 1;
    tick();
    check("start_addr", out_addr, 8'h00);
    do_pop();

    // err_cnt saturation
    for (int i = 0; i < 260; i++) begin
      rand_fields(0); in_cls = 2'd3; in_valid = 1;
      tick();
    end
    check("err_cnt_sat", err_cnt, 8'hFF);
    start = 1; in_valid = 0;
    tick();
    start = 0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_fields(0);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      start     = ($urandom_range(0, 59) == 0);
      tick();
    end
    start = 0;

    // Asynchronous reset with a full buffer
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      rand_fields(1); in_valid = 1;
      tick();
    end
    in_valid = 0;
    #2 reset = 1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_word", out_word, 0);
    exp_q.delete(); m_addr = 0; m_err = 0; m_cnt = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
